// File: rtl/fetch_issue_unit.sv
// rtl/fetch_issue_unit.sv - instruction fetch and issue stage for the basic CPU
//
// Fetches 16-bit instructions over a req/ack handshake, holds them in an
// instruction register for the control decoder, and selects the next PC from
// the decoder's branch result when the instruction retires.
//
// Optional feature: define FETCH_TIMEOUT_EN to bound the FETCH wait to
// TIMEOUT_CYCLES cycles; on expiry the unit parks in ERROR with fetch_err=1.
// Without the macro FETCH waits indefinitely and fetch_err is tied to 0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req, imem_addr         fetch request / address (address = current PC)
//   imem_ack, imem_rdata        memory acknowledge / instruction word
//   instr, opcode, pc_out       instruction register, its opcode and address
//   instr_valid                 instr/opcode valid for the downstream stage
//   stall                       downstream cannot retire this instruction
//   branch, branch_cond         decoder branch flag and datapath condition
//   branch_target               next PC when the branch is taken
//   halted                      HALT_OPCODE has retired
//   fetch_err                   fetch timeout (FETCH_TIMEOUT_EN only)

module fetch_issue_unit #(
    parameter int                  PC_WIDTH       = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
    parameter logic [3:0]          HALT_OPCODE    = 4'b1111,
    parameter int                  TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    output logic [15:0]         instr,
    output logic [3:0]          opcode,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                instr_valid,
    input  logic                stall,
    input  logic                branch,
    input  logic                branch_cond,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                halted,
    output logic                fetch_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
`ifdef FETCH_TIMEOUT_EN
        S_ERROR,
`endif
        S_HALT
    } state_t;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    logic                load_instr;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          tlimit;

    // tcnt counts completed FETCH cycles without ack; the limit is reached on
    // the TIMEOUT_CYCLES-th such cycle, and an ack on that same cycle wins.
    assign tlimit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (state != S_FETCH) begin
            tcnt <= '0;
        end else if (!imem_ack) begin
            tcnt <= tcnt + TW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            instr  <= 16'h0000;
            pc_out <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load_instr) begin
                instr  <= imem_rdata;
                pc_out <= pc;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_instr = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_next = S_ISSUE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tlimit) begin
                    state_next = S_ERROR;
                end
`endif
            end
            S_ISSUE: begin
                // Branch inputs are only looked at on the retiring cycle.
                if (!stall) begin
                    if (instr[15:12] == HALT_OPCODE) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_FETCH;
                        if (branch && branch_cond) begin
                            pc_next = {branch_target[PC_WIDTH-1:1], 1'b0};
                        end else begin
                            pc_next = pc + PC_WIDTH'(2);
                        end
                    end
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERROR: begin
                state_next = S_ERROR;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset drops
    // imem_req and instr_valid immediately.
    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign opcode      = instr[15:12];
    assign instr_valid = (state == S_ISSUE);
    assign halted      = (state == S_HALT);
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = (state == S_ERROR);
`else
    assign fetch_err   = 1'b0;
`endif

endmodule
